aes_tiled_serial: RTL and testbench

Area-scalable, multi-cycle successor of the single-cycle AES tiled functional unit. It performs SubBytes, SubBytes+ShiftRows (hi/lo half) and MixColumns on a 2×32-bit operand pair, using a parametrised number of S-box and MixColumn lanes and sequencing the four byte positions over several cycles. It sits in the execute stage of the core's AES ISE path. Its valid/ready handshake tolerates multi-cycle latency.

---
 rtl/aes_tiled_serial.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_aes_tiled_serial.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_tiled_serial.sv
// aes_tiled_serial: multi-cycle AES SubBytes, SubBytes+ShiftRows and MixColumns unit.
// S-box and MixColumn lane counts trade area against latency (4/lanes BUSY steps).

module aes_sbox_pair (
    input  logic       dec,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse in GF(2^8) as a^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] y;
        logic [7:0] p;
        y = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            y = gf_mul(y, p);
        end
        return y;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    logic [7:0] mi_fwd;
    logic [7:0] aff_inv;
    logic [7:0] s_fwd;
    logic [7:0] s_inv;

    always_comb begin
        mi_fwd  = gf_inv(din);
        s_fwd   = mi_fwd ^ rotl(mi_fwd, 1) ^ rotl(mi_fwd, 2) ^ rotl(mi_fwd, 3)
                ^ rotl(mi_fwd, 4) ^ 8'h63;
        aff_inv = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
        s_inv   = gf_inv(aff_inv);
        dout    = dec ? s_inv : s_fwd;
    end

endmodule

// One output row of (Inv)MixColumns; col[31:24] is the row the result belongs to.
module aes_mixcolumn_byte (
    input  logic [31:0] col,
    input  logic        dec,
    output logic [7:0]  mixed
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            x1[k] = col[8*k +: 8];
            x2[k] = xtime(x1[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
        end
        if (dec) begin
            mixed = (x8[3] ^ x4[3] ^ x2[3]) ^ (x8[2] ^ x2[2] ^ x1[2])
                  ^ (x8[1] ^ x4[1] ^ x1[1]) ^ (x8[0] ^ x1[0]);
        end else begin
            mixed = x2[3] ^ (x2[2] ^ x1[2]) ^ x1[1] ^ x1[0];
        end
    end

endmodule

module aes_tiled_serial #(
    parameter int unsigned SBOX_LANES = 1,
    parameter int unsigned MIX_LANES  = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic        flush,
    input  logic        dec,
    input  logic        op_sb,
    input  logic        op_sbsr,
    input  logic        op_mix,
    input  logic        hi,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        ready,
    output logic [31:0] rd
);

    localparam int unsigned SB_STEPS  = 4 / SBOX_LANES;
    localparam int unsigned MIX_STEPS = 4 / MIX_LANES;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OP_SB, OP_SBSR, OP_MIX} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        dec_q, dec_d;
    logic        hi_q, hi_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rd_q, rd_d;
    logic [1:0]  step_q, step_d;
    logic        ready_q, ready_d;
    logic [1:0]  last_step;

    logic [7:0]  sb_in  [SBOX_LANES];
    logic [7:0]  sb_out [SBOX_LANES];
    logic [31:0] mx_in  [MIX_LANES];
    logic [7:0]  mx_out [MIX_LANES];

    function automatic logic [1:0] lane_pos(input logic [1:0] step, input int unsigned lanes,
                                            input int unsigned j);
        return 2'(32'(step) * lanes + j);
    endfunction

    // ShiftRows is folded into the choice of source byte for each output position.
    function automatic logic [7:0] sbox_src(input op_t op, input logic d, input logic h,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] p);
        logic       use_b;
        logic [1:0] idx;
        idx   = p;
        use_b = h;
        if (op == OP_SB) begin
            use_b = 1'b0;
        end else if (p == 2'd3) begin
            idx   = 2'd1;
            use_b = h ^ d;
        end else if (p == 2'd1) begin
            idx   = 2'd3;
            use_b = ~(h ^ d);
        end
        return use_b ? b[{idx, 3'b000} +: 8] : a[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] mix_src(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] p);
        logic [31:0] c;
        c = p[1] ? {a[23:16], a[31:24], b[23:16], b[31:24]}
                 : {a[7:0],   a[15:8],  b[7:0],   b[15:8]};
        return p[0] ? {c[23:0], c[31:24]} : c;
    endfunction

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_sbox
        aes_sbox_pair u_sbox (
            .dec  (dec_q),
            .din  (sb_in[g]),
            .dout (sb_out[g])
        );
    end

    for (genvar g = 0; g < MIX_LANES; g++) begin : g_mix
        aes_mixcolumn_byte u_mix (
            .col   (mx_in[g]),
            .dec   (dec_q),
            .mixed (mx_out[g])
        );
    end

    // Lane operands for the byte group selected by the current step.
    always_comb begin
        for (int unsigned j = 0; j < SBOX_LANES; j++) begin
            sb_in[j] = sbox_src(op_q, dec_q, hi_q, rs1_q, rs2_q, lane_pos(step_q, SBOX_LANES, j));
        end
        for (int unsigned j = 0; j < MIX_LANES; j++) begin
            mx_in[j] = mix_src(rs1_q, rs2_q, lane_pos(step_q, MIX_LANES, j));
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dec_d     = dec_q;
        hi_d      = hi_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        acc_d     = acc_q;
        rd_d      = rd_q;
        step_d    = step_q;
        ready_d   = 1'b0;
        last_step = (op_q == OP_MIX) ? 2'(MIX_STEPS - 1) : 2'(SB_STEPS - 1);

        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    if (op_mix)       op_d = OP_MIX;
                    else if (op_sb)   op_d = OP_SB;
                    else if (op_sbsr) op_d = OP_SBSR;
                    else              op_d = OP_SBSR;
                    dec_d   = dec;
                    hi_d    = hi;
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    step_d  = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q == OP_MIX) begin
                        for (int unsigned j = 0; j < MIX_LANES; j++) begin
                            acc_d[{lane_pos(step_q, MIX_LANES, j), 3'b000} +: 8] = mx_out[j];
                        end
                    end else begin
                        for (int unsigned j = 0; j < SBOX_LANES; j++) begin
                            acc_d[{lane_pos(step_q, SBOX_LANES, j), 3'b000} +: 8] = sb_out[j];
                        end
                    end
                    step_d = step_q + 2'd1;
                    // Final group: publish the merged result so ready is high during DONE.
                    if (step_q == last_step) begin
                        rd_d    = acc_d;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IDLE;
            op_q    <= OP_SB;
            dec_q   <= 1'b0;
            hi_q    <= 1'b0;
            rs1_q   <= 32'h0;
            rs2_q   <= 32'h0;
            acc_q   <= 32'h0;
            rd_q    <= 32'h0;
            step_q  <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dec_q   <= dec_d;
            hi_q    <= hi_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            step_q  <= step_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign rd    = rd_q;

endmodule

// File: tb/tb_aes_tiled_serial.sv
// Directed bench for aes_tiled_serial: three lane configurations driven in parallel,
// checked against hand-computed AES results and per-configuration latencies.

module tb_aes_tiled_serial;

    typedef struct {
        logic [2:0]  op;   // {mix, sbsr, sb}
        logic        dec;
        logic        hi;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        flush;
    logic        dec;
    logic        op_sb;
    logic        op_sbsr;
    logic        op_mix;
    logic        hi;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        ready_w [3];
    logic [31:0] rd_w    [3];
    logic [31:0] rd_model[3];

    int n_chk  = 0;
    int n_pass = 0;

    vec_t tbl [14];

    // Configurations: (SBOX, MIX) = (1,1), (2,4), (4,2)
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_tiled_serial #(
            .SBOX_LANES (1 << g),
            .MIX_LANES  (g == 0 ? 1 : (g == 1 ? 4 : 2))
        ) u_dut (
            .g_clk   (clk),
            .g_reset (rst),
            .valid   (valid),
            .flush   (flush),
            .dec     (dec),
            .op_sb   (op_sb),
            .op_sbsr (op_sbsr),
            .op_mix  (op_mix),
            .hi      (hi),
            .rs1     (rs1),
            .rs2     (rs2),
            .ready   (ready_w[g]),
            .rd      (rd_w[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int n_of(input logic is_mix, input int d);
        int sb_l;
        int mx_l;
        sb_l = 1 << d;
        mx_l = (d == 0) ? 1 : ((d == 1) ? 4 : 2);
        return is_mix ? 4 / mx_l : 4 / sb_l;
    endfunction

    task automatic chk(input string what, input int d, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", what, d, got, want);
    endtask

    // Called at a negedge; the request is accepted at the next posedge, then all
    // inputs are scrambled so only the captured operands can produce the result.
    task automatic issue(input vec_t v);
        {op_mix, op_sbsr, op_sb} = v.op;
        dec   = v.dec;
        hi    = v.hi;
        rs1   = v.rs1;
        rs2   = v.rs2;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        {op_mix, op_sbsr, op_sb} = ~v.op;
        dec   = ~v.dec;
        hi    = ~v.hi;
        rs1   = ~v.rs1;
        rs2   = ~v.rs2;
    endtask

    task automatic observe(input vec_t v, input string name);
        int          first [3];
        int          cnt   [3];
        logic [31:0] got   [3];
        logic        hold  [3];
        for (int d = 0; d < 3; d++) begin
            first[d] = -1;
            cnt[d]   = 0;
            got[d]   = 32'h0;
            hold[d]  = 1'b1;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (ready_w[d]) begin
                    cnt[d]++;
                    if (first[d] < 0) begin
                        first[d] = k;
                        got[d]   = rd_w[d];
                    end
                end else if (rd_w[d] !== (first[d] < 0 ? rd_model[d] : v.exp)) begin
                    hold[d] = 1'b0;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk({name, "_latency"}, d, 32'(first[d]), 32'(n_of(v.op[2], d)));
            chk({name, "_rd"},      d, got[d], v.exp);
            chk({name, "_pulses"},  d, 32'(cnt[d]), 32'd1);
            chk({name, "_rd_hold"}, d, 32'(hold[d]), 32'd1);
            rd_model[d] = v.exp;
        end
    endtask

    initial begin
        logic        r1    [3];
        int          first [3];
        int          second[3];
        logic [31:0] got   [3];
        int          cnt   [3];

        clk = 1'b0; rst = 1'b1; valid = 1'b0; flush = 1'b0; dec = 1'b0; hi = 1'b0;
        op_sb = 1'b0; op_sbsr = 1'b0; op_mix = 1'b0; rs1 = 32'h0; rs2 = 32'h0;
        for (int d = 0; d < 3; d++) rd_model[d] = 32'h0;

        tbl[0]  = '{3'b001, 1'b0, 1'b0, 32'h53020100, 32'h00000000, 32'hED777C63};
        tbl[1]  = '{3'b001, 1'b1, 1'b0, 32'hED777C63, 32'h00000000, 32'h53020100};
        tbl[2]  = '{3'b010, 1'b0, 1'b0, 32'h03020100, 32'h07060504, 32'h7C77C563};
        tbl[3]  = '{3'b010, 1'b0, 1'b1, 32'h03020100, 32'h07060504, 32'h6B6F7BF2};
        tbl[4]  = '{3'b000, 1'b0, 1'b0, 32'h03020100, 32'h07060504, 32'h7C77C563};
        tbl[5]  = '{3'b010, 1'b1, 1'b0, 32'h7B777C63, 32'hC56F6BF2, 32'h05020300};
        tbl[6]  = '{3'b010, 1'b1, 1'b1, 32'h7B777C63, 32'hC56F6BF2, 32'h01060704};
        tbl[7]  = '{3'b100, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 32'h01010101};
        tbl[8]  = '{3'b100, 1'b1, 1'b0, 32'h01010101, 32'h01010101, 32'h01010101};
        tbl[9]  = '{3'b100, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
        tbl[10] = '{3'b100, 1'b0, 1'b0, 32'h13DB0AF2, 32'h45535C22, 32'h4D8EDC9F};
        tbl[11] = '{3'b100, 1'b1, 1'b0, 32'h4D8EDC9F, 32'hBCA19D58, 32'h13DB0AF2};
        tbl[12] = '{3'b111, 1'b0, 1'b1, 32'h13DB0AF2, 32'h45535C22, 32'h4D8EDC9F};
        tbl[13] = '{3'b011, 1'b0, 1'b1, 32'h53020100, 32'h07060504, 32'hED777C63};

        #12;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", d, 32'(ready_w[d]), 32'd0);
            chk("reset_rd",    d, rd_w[d], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(tbl[i]);
            observe(tbl[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // flush while IDLE blocks acceptance
        {op_mix, op_sbsr, op_sb} = 3'b001;
        rs1   = 32'h03020100;
        valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        for (int d = 0; d < 3; d++) cnt[d] = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) if (ready_w[d]) cnt[d]++;
        end
        for (int d = 0; d < 3; d++) begin
            chk("idle_flush_pulses", d, 32'(cnt[d]), 32'd0);
            chk("idle_flush_rd",     d, rd_w[d], rd_model[d]);
        end
        @(negedge clk);

        // flush during BUSY step 1; the single-step configuration finishes first
        issue(tbl[5]);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) r1[d] = ready_w[d];
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("busy_flush_ready", d, 32'({r1[d], ready_w[d]}), 32'd0);
            chk("busy_flush_rd",    d, rd_w[d], rd_model[d]);
        end
        chk("busy_flush_single_step_ready", 2, 32'(r1[2]), 32'd1);
        chk("busy_flush_single_step_rd",    2, rd_w[2], tbl[5].exp);
        rd_model[2] = tbl[5].exp;
        @(negedge clk);
        flush = 1'b0;
        issue(tbl[2]);
        observe(tbl[2], "after_flush");
        @(negedge clk);

        // asynchronous reset between edges while BUSY
        issue(tbl[0]);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async_reset_ready", d, 32'(ready_w[d]), 32'd0);
            chk("async_reset_rd",    d, rd_w[d], 32'h0);
            rd_model[d] = 32'h0;
        end
        @(negedge clk);
        rst = 1'b0;
        issue(tbl[1]);
        observe(tbl[1], "after_reset");
        @(negedge clk);

        // valid held high: each unit restarts every N+2 cycles
        {op_mix, op_sbsr, op_sb} = tbl[0].op;
        dec   = tbl[0].dec;
        hi    = tbl[0].hi;
        rs1   = tbl[0].rs1;
        rs2   = tbl[0].rs2;
        valid = 1'b1;
        for (int d = 0; d < 3; d++) begin
            first[d]  = -1;
            second[d] = -1;
            got[d]    = 32'h0;
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (ready_w[d]) begin
                    if (first[d] < 0) begin
                        first[d] = k;
                        got[d]   = rd_w[d];
                    end else if (second[d] < 0) begin
                        second[d] = k;
                    end
                end
            end
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (8) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("b2b_interval", d, 32'(second[d] - first[d]), 32'(n_of(1'b0, d) + 2));
            chk("b2b_rd",       d, got[d], tbl[0].exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
